// File: rtl/vga_sync_rx.sv
// vga_sync_rx: VGA timing receiver; recovers pixel coordinates, checks line/frame timing, reports lock.
// Optional macro VGA_RX_CRC_EN adds a CRC-16-CCITT of each frame's visible pixels on frame_crc.
module vga_sync_rx #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit SYNC_ACT    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ena,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [1:0]  r,
    input  logic [1:0]  g,
    input  logic [1:0]  b,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [5:0]  rgb,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [15:0] frame_crc
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_LAST = 11'(H_SYNC - 1);
    localparam logic [10:0] H_START     = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END       = 11'(H_SYNC + H_BACK + H_VISIBLE);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_START     = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_END       = 10'(V_SYNC + V_BACK + V_VISIBLE);
    localparam logic [2:0]  LOCK_N      = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic        hs_act_q, hs_act_d, vs_act_q, vs_act_d, vs_line_q, vs_line_d;
    logic [2:0]  count_q, count_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [5:0]  rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic        timing_err_q, timing_err_d;
    logic        hs_now, vs_now, hs_lead, hs_trail, vs_lead, visible, timeout, err;

    // Edge detection runs on the sync activity level, so SYNC_ACT only matters here.
    always_comb begin
        hs_now    = (hsync == SYNC_ACT);
        vs_now    = (vsync == SYNC_ACT);
        hs_lead   = ena && hs_now && !hs_act_q;
        hs_trail  = ena && !hs_now && hs_act_q;
        vs_lead   = ena && vs_now && !vs_act_q;
        hs_act_d  = ena ? hs_now : hs_act_q;
        vs_act_d  = ena ? vs_now : vs_act_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        vs_line_d = vs_line_q;
        if (ena) begin
            if (hs_lead)
                hcnt_d = '0;
            else if (hcnt_q != 11'h7FF)
                hcnt_d = hcnt_q + 11'd1;
        end
        if (hs_lead) begin
            vs_line_d = vs_now;
            if (vs_now && !vs_line_q)
                vcnt_d = '0;
            else if (vcnt_q != 10'h3FF)
                vcnt_d = vcnt_q + 10'd1;
        end
    end

    // Timeouts are checked in every state; an error always beats a same-cycle lock step.
    always_comb begin
        timeout = ena && ((hcnt_d == 11'h7FF && hcnt_q != 11'h7FF) ||
                          (vcnt_d == 10'h3FF && vcnt_q != 10'h3FF));
        err = timeout;
        if (state_q != SEARCH) begin
            if (hs_lead && hcnt_q != H_LAST)
                err = 1'b1;
            if (hs_trail && hcnt_q != H_SYNC_LAST)
                err = 1'b1;
            if (vs_lead && vcnt_q != V_LAST)
                err = 1'b1;
        end
        visible = ena && hcnt_d >= H_START && hcnt_d < H_END &&
                  vcnt_d >= V_START && vcnt_d < V_END;
        state_d = state_q;
        count_d = count_q;
        if (err) begin
            state_d = SEARCH;
            count_d = '0;
        end else if (vs_lead) begin
            case (state_q)
                SEARCH: begin
                    state_d = ACQUIRE;
                    count_d = '0;
                end
                ACQUIRE: begin
                    count_d = count_q + 3'd1;
                    if (count_q + 3'd1 == LOCK_N)
                        state_d = LOCKED;
                end
                default: ;
            endcase
        end
        x_d   = x_q;
        y_d   = y_q;
        rgb_d = rgb_q;
        if (visible) begin
            x_d   = 10'(hcnt_d - H_START);
            y_d   = vcnt_d - V_START;
            rgb_d = {r, g, b};
        end
        pix_valid_d   = visible && state_q == LOCKED && !err;
        frame_start_d = vs_lead;
        timing_err_d  = err;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= SEARCH;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hs_act_q      <= 1'b0;
            vs_act_q      <= 1'b0;
            vs_line_q     <= 1'b0;
            count_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            timing_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hs_act_q      <= hs_act_d;
            vs_act_q      <= vs_act_d;
            vs_line_q     <= vs_line_d;
            count_q       <= count_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
            timing_err_q  <= timing_err_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign rgb         = rgb_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign timing_err  = timing_err_q;
    assign locked      = (state_q == LOCKED);

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_acc_q, crc_acc_d, frame_crc_q, frame_crc_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc_in, input logic [5:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 5; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ 16'h1021;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    // Accumulates regardless of lock so the CRC also reflects frames seen while acquiring.
    always_comb begin
        crc_acc_d   = crc_acc_q;
        frame_crc_d = frame_crc_q;
        if (vs_lead) begin
            frame_crc_d = crc_acc_q;
            crc_acc_d   = 16'hFFFF;
        end else if (visible) begin
            crc_acc_d = crc_step(crc_acc_q, {r, g, b});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            crc_acc_q   <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// Testbench for vga_sync_rx using a scaled-down timing so whole frames fit in a short run.
module tb_vga_sync_rx;
    localparam int HV = 8, HF = 2, HS = 3, HB = 2, HT = HV + HF + HS + HB;
    localparam int VV = 4, VF = 1, VS = 2, VB = 2, VT = VV + VF + VS + VB;
    localparam int LOCK = 2;
    localparam bit SYNC_ACT = 1'b0;

    logic        clock = 1'b0, reset = 1'b1, ena = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [1:0]  r = '0, g = '0, b = '0;
    logic [9:0]  x, y;
    logic [5:0]  rgb;
    logic        pix_valid, frame_start, locked, timing_err;
    logic [15:0] frame_crc;
    logic [45:0] obs, expv;

    int tests_run = 0, tests_failed = 0, idle_pulses = 0;

    int          m_h, m_v, m_mode, m_cnt;
    bit          m_hs_prev, m_vs_prev, m_vs_line;
    logic [15:0] m_crc, m_frame_crc;
    logic [9:0]  e_x, e_y;
    logic [5:0]  e_rgb;
    bit          e_pv, e_fs, e_te;

    vga_sync_rx #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACT(SYNC_ACT), .LOCK_FRAMES(LOCK)
    ) dut (
        .clock(clock), .reset(reset), .ena(ena), .hsync(hsync), .vsync(vsync),
        .r(r), .g(g), .b(b), .x(x), .y(y), .rgb(rgb), .pix_valid(pix_valid),
        .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
        .frame_crc(frame_crc)
    );

    always #5 clock = ~clock;

    assign obs = {x, y, rgb, pix_valid, frame_start, timing_err, locked, frame_crc};

    // CRC-16-CCITT in the data-aligned-to-top form, six data bits per pixel.
    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [5:0] d);
        logic [15:0] c;
        c = c_in ^ {d, 10'b0};
        repeat (6) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic build_expv();
`ifdef VGA_RX_CRC_EN
        expv = {e_x, e_y, e_rgb, e_pv, e_fs, e_te, (m_mode == 2), m_frame_crc};
`else
        expv = {e_x, e_y, e_rgb, e_pv, e_fs, e_te, (m_mode == 2), 16'h0000};
`endif
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 0; m_cnt = 0;
        m_hs_prev = 0; m_vs_prev = 0; m_vs_line = 0;
        m_crc = 16'hFFFF; m_frame_crc = 16'h0000;
        e_x = '0; e_y = '0; e_rgb = '0; e_pv = 0; e_fs = 0; e_te = 0;
        build_expv();
    endtask

    // Reference: mode 0 = searching, 1 = acquiring, 2 = locked.
    task automatic model_step(input bit hs_a, input bit vs_a, input logic [5:0] c);
        bit hl, ht, vl, vis, err;
        int nh, nv;
        hl = hs_a && !m_hs_prev;
        ht = !hs_a && m_hs_prev;
        vl = vs_a && !m_vs_prev;
        nh = hl ? 0 : (m_h < 2047 ? m_h + 1 : 2047);
        nv = m_v;
        if (hl) begin
            nv = (vs_a && !m_vs_line) ? 0 : (m_v < 1023 ? m_v + 1 : 1023);
            m_vs_line = vs_a;
        end
        err = (nh == 2047 && m_h != 2047) || (nv == 1023 && m_v != 1023);
        if (m_mode != 0 && ((hl && m_h != HT - 1) || (ht && m_h != HS - 1) || (vl && m_v != VT - 1)))
            err = 1;
        vis = nh >= HS + HB && nh < HS + HB + HV && nv >= VS + VB && nv < VS + VB + VV;
        e_pv = vis && m_mode == 2 && !err;
        e_fs = vl;
        e_te = err;
        if (vis) begin
            e_x = 10'(nh - (HS + HB));
            e_y = 10'(nv - (VS + VB));
            e_rgb = c;
        end
        if (vl) begin
            m_frame_crc = m_crc;
            m_crc = 16'hFFFF;
        end else if (vis) begin
            m_crc = crc_model(m_crc, c);
        end
        if (err) begin
            m_mode = 0; m_cnt = 0;
        end else if (vl) begin
            if (m_mode == 0) begin
                m_mode = 1; m_cnt = 0;
            end else if (m_mode == 1) begin
                m_cnt++;
                if (m_cnt == LOCK) m_mode = 2;
            end
        end
        m_h = nh; m_v = nv; m_hs_prev = hs_a; m_vs_prev = vs_a;
        build_expv();
    endtask

    // Random idle clocks with junk on the inputs, then one strobed pixel.
    task automatic drive_pixel(input bit hs_a, input bit vs_a, input logic [5:0] c);
        int gap;
        gap = $urandom_range(0, 2);
        for (int i = 0; i < gap; i++) begin
            ena = 1'b0;
            hsync = 1'($urandom); vsync = 1'($urandom); {r, g, b} = 6'($urandom);
            @(posedge clock); #1;
            if (pix_valid || frame_start || timing_err) idle_pulses++;
        end
        ena = 1'b1;
        hsync = hs_a ? SYNC_ACT : !SYNC_ACT;
        vsync = vs_a ? SYNC_ACT : !SYNC_ACT;
        {r, g, b} = c;
        @(posedge clock); #1;
        ena = 1'b0;
        model_step(hs_a, vs_a, c);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if (obs !== 46'h0) begin tests_failed++; $display("[TB] FAIL reset_outputs got=%h want=0", obs); end
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (obs !== 46'h0) begin tests_failed++; $display("[TB] FAIL idle_after_reset got=%h want=0", obs); end
    endtask

    task automatic test_lock();
        int te_seen = 0;
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < VT; l++)
                for (int p = 0; p < HT; p++) begin
                    drive_pixel(p < HS, l < VS, 6'($urandom));
                    if (timing_err) te_seen++;
                    tests_run++;
                    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL lock_px f%0d l%0d p%0d got=%h want=%h", f, l, p, obs, expv); end
                    if (f == 1 && l == 0 && p == 0) begin
                        tests_run++;
                        if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL lock_early got=%b want=0", locked); end
                    end
                    if (f == 2 && l == 0 && p == 0) begin
                        tests_run++;
                        if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL lock_after_2_frames got=%b want=1", locked); end
                    end
                end
        tests_run++;
        if (te_seen !== 0) begin tests_failed++; $display("[TB] FAIL lock_no_err got=%0d want=0", te_seen); end
        tests_run++;
        if (idle_pulses !== 0) begin tests_failed++; $display("[TB] FAIL idle_pulses got=%0d want=0", idle_pulses); end
    endtask

    task automatic test_long_line();
        for (int f = 0; f < 4; f++)
            for (int l = 0; l < VT; l++)
                for (int p = 0; p < ((f == 0 && l == 3) ? HT + 1 : HT); p++) begin
                    drive_pixel(p < HS, l < VS, 6'($urandom));
                    tests_run++;
                    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL long_px f%0d l%0d p%0d got=%h want=%h", f, l, p, obs, expv); end
                    if (f == 0 && l == 4 && p == 0) begin
                        tests_run++;
                        if ({timing_err, locked} !== 2'b10) begin tests_failed++; $display("[TB] FAIL long_line_err got=%b%b want=10", timing_err, locked); end
                    end
                    if (f == 2 && l == 0 && p == 0) begin
                        tests_run++;
                        if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL long_relock_early got=%b want=0", locked); end
                    end
                    if (f == 3 && l == 0 && p == 0) begin
                        tests_run++;
                        if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL long_relock got=%b want=1", locked); end
                    end
                end
    endtask

    task automatic test_coords();
        logic [5:0] c;
        for (int l = 0; l < VT; l++)
            for (int p = 0; p < HT; p++) begin
                c = (l == VS + VB && p == HS + HB) ? 6'h2A : 6'($urandom);
                drive_pixel(p < HS, l < VS, c);
                tests_run++;
                if (obs !== expv) begin tests_failed++; $display("[TB] FAIL coord_px l%0d p%0d got=%h want=%h", l, p, obs, expv); end
                if (l == VS + VB && p == HS + HB - 1) begin
                    tests_run++;
                    if (pix_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL coord_before_visible got=%b want=0", pix_valid); end
                end
                if (l == VS + VB && p == HS + HB) begin
                    tests_run++;
                    if ({pix_valid, x, y, rgb} !== {1'b1, 10'd0, 10'd0, 6'h2A}) begin tests_failed++; $display("[TB] FAIL coord_first got=%b/%0d/%0d/%h want=1/0/0/2a", pix_valid, x, y, rgb); end
                end
                if (l == VS + VB + VV - 1 && p == HS + HB + HV - 1) begin
                    tests_run++;
                    if ({pix_valid, x, y} !== {1'b1, 10'(HV - 1), 10'(VV - 1)}) begin tests_failed++; $display("[TB] FAIL coord_last got=%b/%0d/%0d want=1/%0d/%0d", pix_valid, x, y, HV - 1, VV - 1); end
                end
            end
    endtask

    task automatic test_timeout();
        int te_seen = 0;
        for (int i = 0; i < 2100; i++) begin
            drive_pixel(1'b0, 1'b0, 6'($urandom));
            if (timing_err) te_seen++;
            tests_run++;
            if (obs !== expv) begin tests_failed++; $display("[TB] FAIL timeout_px i%0d got=%h want=%h", i, obs, expv); end
        end
        tests_run++;
        if ({te_seen == 1, locked} !== 2'b10) begin tests_failed++; $display("[TB] FAIL timeout_err pulses=%0d locked=%b want 1 pulse, locked=0", te_seen, locked); end
        for (int f = 0; f < 3; f++)
            for (int l = 0; l < VT; l++)
                for (int p = 0; p < HT; p++) begin
                    drive_pixel(p < HS, l < VS, 6'($urandom));
                    tests_run++;
                    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL timeout_relock_px f%0d l%0d p%0d got=%h want=%h", f, l, p, obs, expv); end
                end
        tests_run++;
        if (locked !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_relock got=%b want=1", locked); end
    endtask

    task automatic test_sync_width_reset();
        bit done = 0;
        for (int l = 0; l < VT && !done; l++)
            for (int p = 0; p < HT && !done; p++) begin
                drive_pixel(p < ((l == 5) ? HS - 1 : HS), l < VS, 6'($urandom_range(1, 63)));
                tests_run++;
                if (obs !== expv) begin tests_failed++; $display("[TB] FAIL width_px l%0d p%0d got=%h want=%h", l, p, obs, expv); end
                if (l == 5 && p == HS - 1) begin
                    tests_run++;
                    if ({timing_err, locked} !== 2'b10) begin tests_failed++; $display("[TB] FAIL sync_width_err got=%b%b want=10", timing_err, locked); end
                end
                if (l == 6 && p == HS + HB + 3) begin
                    reset = 1'b1;
                    @(posedge clock); #1;
                    tests_run++;
                    if (obs !== 46'h0) begin tests_failed++; $display("[TB] FAIL reset_mid_frame got=%h want=0", obs); end
                    reset = 1'b0;
                    model_reset();
                    done = 1;
                end
            end
    endtask

    task automatic test_crc();
        logic [15:0] gold = 16'hFFFF;
        for (int i = 0; i < HV * VV; i++) gold = crc_model(gold, 6'h00);
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < VT; l++)
                for (int p = 0; p < HT; p++) begin
                    drive_pixel(p < HS, l < VS, 6'h00);
                    tests_run++;
                    if (obs !== expv) begin tests_failed++; $display("[TB] FAIL crc_px f%0d l%0d p%0d got=%h want=%h", f, l, p, obs, expv); end
                    if (f == 1 && l == 0 && p == 0) begin
                        tests_run++;
`ifdef VGA_RX_CRC_EN
                        if (frame_crc !== gold) begin tests_failed++; $display("[TB] FAIL crc_zero_frame got=%h want=%h", frame_crc, gold); end
`else
                        if (frame_crc !== 16'h0000) begin tests_failed++; $display("[TB] FAIL crc_disabled got=%h want=0000 (gold %h unused)", frame_crc, gold); end
`endif
                        tests_run++;
                        if (locked !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_relock_early got=%b want=0", locked); end
                    end
                end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_long_line();
        test_coords();
        test_timeout();
        test_sync_width_reset();
        test_crc();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
